// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch / data) arbiter in front of a single-port
// memory. Each access takes IDLE (grant) -> ACC (memory strobe) -> RESP
// (capture read data); the owner's rvalid pulses in the following IDLE cycle.
// Optional build macro MEM_ARB_STARVE_EN enables the fetch anti-starvation
// counter; without it data requests always win.
module mem_arbiter #(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_wmask,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        m_en,
    output logic        m_we,
    output logic [3:0]  m_wmask,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_D} own_t;

    state_t      state, state_nxt;
    own_t        own;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wmask;
    logic        lat_we;
    logic        lat_mis;
    logic        if_mis;
    logic        d_mis;
    logic        d_win;

    if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_bad_lim
        $error("mem_arbiter: STARVE_LIM must be in 1..15");
    end

    // Misalignment classification of the request fields presented at grant
    always_comb begin
        if_mis = (if_addr[1:0] != 2'b00);
        d_mis  = ((d_wmask == 4'b1111) && (d_addr[1:0] != 2'b00)) ||
                 (((d_wmask == 4'b0011) || (d_wmask == 4'b1100)) && d_addr[0]);
    end

`ifdef MEM_ARB_STARVE_EN
    logic [3:0] scnt;

    assign d_win = d_req && !(if_req && (scnt == 4'(STARVE_LIM)));

    // Count data grants taken while fetch waits; any grant that leaves fetch
    // not waiting (fetch grant, or data grant with no fetch request) clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt <= '0;
        end else if (d_gnt) begin
            if (!if_req)
                scnt <= '0;
            else if (scnt != 4'(STARVE_LIM))
                scnt <= scnt + 4'd1;
        end else if (if_gnt) begin
            scnt <= '0;
        end
    end
`else
    assign d_win = d_req;
`endif

    // Next-state and combinational grant; grants only in IDLE and never in reset
    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (d_win) begin
                        d_gnt     = 1'b1;
                        state_nxt = ACC;
                    end else if (if_req) begin
                        if_gnt    = 1'b1;
                        state_nxt = ACC;
                    end
                end
            end
            ACC:     state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Latch owner and request fields in the grant cycle only
    always_ff @(posedge clk) begin
        if (rst) begin
            own       <= OWN_IF;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
            lat_we    <= 1'b0;
            lat_mis   <= 1'b0;
        end else if (d_gnt) begin
            own       <= OWN_D;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            lat_wmask <= d_wmask;
            lat_we    <= d_we;
            lat_mis   <= d_mis;
        end else if (if_gnt) begin
            own       <= OWN_IF;
            lat_addr  <= if_addr;
            lat_wdata <= '0;
            lat_wmask <= '0;
            lat_we    <= 1'b0;
            lat_mis   <= if_mis;
        end
    end

    // Capture read data in RESP and raise the owner's one-cycle response pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            if (state == RESP) begin
                if (own == OWN_D) begin
                    d_rvalid <= 1'b1;
                    d_err    <= lat_mis;
                    if (!lat_mis && !lat_we)
                        d_rdata <= m_rdata;
                end else begin
                    if_rvalid <= 1'b1;
                    if_err    <= lat_mis;
                    if (!lat_mis)
                        if_rdata <= m_rdata;
                end
            end
        end
    end

    assign m_en    = (state == ACC) && !lat_mis;
    assign m_we    = m_en && lat_we;
    assign m_wmask = lat_wmask;
    assign m_addr  = lat_addr;
    assign m_wdata = lat_wdata;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural single-port memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_wmask;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        m_en, m_we;
    logic [3:0]  m_wmask;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mem_arbiter #(.STARVE_LIM(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .m_en(m_en), .m_we(m_we), .m_wmask(m_wmask), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: read data valid the cycle after m_en; byte-masked writes
    bit [31:0] mem [0:16383];
    always @(posedge clk) begin
        if (rst)
            mem[14'h0040] <= 32'h0000_0073;
        if (m_en) begin
            m_rdata <= mem[m_addr[15:2]];
            if (m_we)
                for (int b = 0; b < 4; b++)
                    if (m_wmask[b])
                        mem[m_addr[15:2]][8*b +: 8] <= m_wdata[8*b +: 8];
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its end, got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One isolated access: grant at N, strobe at N+1, response at N+3
    task automatic run_access(input string tag, input bit is_d, input bit we,
                              input logic [3:0] mask, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit mis,
                              input logic [31:0] exp_rdata);
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_wmask = mask; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        #1;
        check({tag, "_dgnt"}, d_gnt, is_d);
        check({tag, "_ifgnt"}, if_gnt, !is_d);
        @(negedge clk);
        d_req = 1'b0; if_req = 1'b0;
        d_we = 1'b0; d_wmask = 4'h0; d_addr = '0; d_wdata = '0; if_addr = '0;
        #1;
        check({tag, "_men"}, m_en, !mis);
        check({tag, "_mwe"}, m_we, is_d && we && !mis);
        check({tag, "_busy1"}, busy, 1'b1);
        if (!mis) begin
            check({tag, "_maddr"}, m_addr, addr);
            check({tag, "_mwmask"}, m_wmask, is_d ? mask : 4'h0);
            if (is_d && we) check({tag, "_mwdata"}, m_wdata, wdata);
        end
        @(negedge clk); #1;
        check({tag, "_men_resp"}, m_en, 1'b0);
        check({tag, "_rv_early"}, is_d ? d_rvalid : if_rvalid, 1'b0);
        @(negedge clk); #1;
        check({tag, "_rvalid"}, is_d ? d_rvalid : if_rvalid, 1'b1);
        check({tag, "_other_rv"}, is_d ? if_rvalid : d_rvalid, 1'b0);
        check({tag, "_err"}, is_d ? d_err : if_err, mis);
        check({tag, "_rdata"}, is_d ? d_rdata : if_rdata, exp_rdata);
        check({tag, "_busy0"}, busy, 1'b0);
        @(negedge clk); #1;
        check({tag, "_rv_pulse"}, is_d ? d_rvalid : if_rvalid, 1'b0);
        check({tag, "_err_low"}, is_d ? d_err : if_err, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_wmask = 4'hf; d_addr = 32'h4000; d_wdata = '0;

        // Reset dominates requests; outputs at reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_dgnt", d_gnt, 1'b0);
        check("rst_ifgnt", if_gnt, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_men", m_en, 1'b0);
        check("rst_maddr", m_addr, 32'h0);
        check("rst_drdata", d_rdata, 32'h0);
        check("rst_ifrdata", if_rdata, 32'h0);
        check("rst_rvalid", {30'd0, d_rvalid, if_rvalid}, 32'h0);

        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; if_addr = '0; d_addr = '0; d_wmask = '0;
        #1;
        check("idle_nogrant", {30'd0, d_gnt, if_gnt}, 32'h0);

        run_access("fetch100", 1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 1'b0, 32'h0000_0073);
        run_access("store4000", 1'b1, 1'b1, 4'hf, 32'h0000_4000, 32'h8765_4321, 1'b0, 32'h0);
        run_access("load4000", 1'b1, 1'b0, 4'hf, 32'h0000_4000, 32'h0, 1'b0, 32'h8765_4321);
        check("if_rdata_hold", if_rdata, 32'h0000_0073);
        run_access("load4002_mis", 1'b1, 1'b0, 4'hf, 32'h0000_4002, 32'h0, 1'b1, 32'h8765_4321);
        run_access("sth4006", 1'b1, 1'b1, 4'hc, 32'h0000_4006, 32'hBEEF_0000, 1'b0, 32'h8765_4321);
        run_access("sth4001_mis", 1'b1, 1'b1, 4'h3, 32'h0000_4001, 32'h0000_1111, 1'b1, 32'h8765_4321);
        run_access("load4004", 1'b1, 1'b0, 4'hf, 32'h0000_4004, 32'h0, 1'b0, 32'hBEEF_0000);
        run_access("reload4000", 1'b1, 1'b0, 4'hf, 32'h0000_4000, 32'h0, 1'b0, 32'h8765_4321);
        run_access("fetch102_mis", 1'b0, 1'b0, 4'h0, 32'h0000_0102, 32'h0, 1'b1, 32'h0000_0073);

        // Both requesters held: one grant every third cycle, none while busy
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if_req = 1'b1; if_addr = 32'h100;
                d_req = 1'b1; d_we = 1'b0; d_wmask = 4'hf; d_addr = 32'h4000;
            end
            #1;
            if ((c % 3) == 0) begin
`ifdef MEM_ARB_STARVE_EN
                check("arb_dgnt", d_gnt, ((c / 3) % 5) != 4);
                check("arb_ifgnt", if_gnt, ((c / 3) % 5) == 4);
`else
                check("arb_dgnt", d_gnt, 1'b1);
                check("arb_ifgnt", if_gnt, 1'b0);
`endif
            end else begin
                check("arb_busy_nogrant", {30'd0, d_gnt, if_gnt}, 32'h0);
            end
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0; if_addr = '0; d_addr = '0; d_wmask = '0;
        repeat (3) @(negedge clk);

        // Reset during ACC of a load aborts the access
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_wmask = 4'hf; d_addr = 32'h4000;
        #1;
        check("abort_dgnt", d_gnt, 1'b1);
        @(negedge clk);
        d_req = 1'b0; d_wmask = '0; d_addr = '0;
        rst = 1'b1;
        #1;
        check("abort_men_kept", m_en, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_rvalid", d_rvalid, 1'b0);
        check("abort_men", m_en, 1'b0);
        check("abort_maddr", m_addr, 32'h0);
        check("abort_drdata", d_rdata, 32'h0);
        check("abort_ifrdata", if_rdata, 32'h0);
        @(negedge clk); #1;
        check("abort_no_late_rv", {30'd0, d_rvalid, if_rvalid}, 32'h0);
        @(negedge clk); #1;
        check("abort_no_late_rv2", {30'd0, d_rvalid, if_rvalid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 4, meaning consecutive data grants allowed while fetch waits (range 1..15).
REQ-002 SHALL have ports: clk input 1 (single clock, rising edge), rst input 1 (synchronous, active-high).
REQ-003 SHALL have ports: if_req input 1 (fetch request), if_addr input 32 (fetch byte address).
REQ-004 SHALL have ports: if_gnt output 1 (fetch accepted), if_rvalid output 1 (fetch response pulse), if_rdata output 32 (fetched word), if_err output 1 (fetch misaligned, qualifies if_rvalid).
REQ-005 SHALL have ports: d_req input 1, d_we input 1, d_wmask input 4, d_addr input 32, d_wdata input 32 (data request fields).
REQ-006 SHALL have ports: d_gnt output 1, d_rvalid output 1 (load data / store ack pulse), d_rdata output 32, d_err output 1 (misaligned, qualifies d_rvalid).
REQ-007 SHALL have ports: m_en output 1, m_we output 1, m_wmask output 4, m_addr output 32 (byte address), m_wdata output 32, m_rdata input 32 (single-port memory, read data valid one cycle after m_en).
REQ-008 SHALL have port busy output 1, high in every state except IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, ACC, RESP; owner register OWN (IF/D) selects routing in ACC/RESP.
REQ-010 IDLE: if any request, SHALL pulse exactly one gnt combinationally, latch owner's address/we/wmask/wdata, go to ACC; else stay IDLE.
REQ-011 Requesters SHALL hold req and fields stable until gnt; arbiter SHALL sample them only in the gnt cycle.
REQ-012 Both req in IDLE: data SHALL win, except per REQ-022.
REQ-013 ACC: SHALL drive m_en=1 and m_* from latched fields for exactly one cycle, then go to RESP; m_en=0 and m_we=0 in all other states.
REQ-014 Fetch accesses SHALL drive m_we=0, m_wmask=0000.
REQ-015 RESP: SHALL register m_rdata into owner's rdata register; go to IDLE; owner's rvalid SHALL be high for exactly the next cycle (IDLE cycle).
REQ-016 Latency: gnt in cycle N -> m_en in N+1 -> rvalid/rdata visible in N+3; new gnt possible in N+3; max one access per 3 cycles.
REQ-017 Store (d_we=1) SHALL still pulse d_rvalid as ack; d_rdata SHALL keep previous value.
REQ-018 rdata registers SHALL hold value until next response of same requester.
REQ-019 Misalignment at grant: fetch with if_addr[1:0]!=0; data with wmask 1111 and addr[1:0]!=0, or wmask 0011/1100 and addr[0]=1 (loads and stores). SHALL NOT assert m_en in ACC; SHALL pulse rvalid with err=1 at N+3; rdata unchanged.
REQ-020 err SHALL be 0 whenever rvalid is 0 and on all aligned responses.
REQ-021 Requests arriving while busy SHALL wait; no gnt outside IDLE.

Reset
REQ-022 (anti-starvation, see Configuration) counter SCNT increments on each data grant made while if_req=1, saturates at STARVE_LIM; clears on fetch grant or data grant with if_req=0; when SCNT==STARVE_LIM and both req, fetch SHALL win.
REQ-023 rst sampled high at a rising edge SHALL force state IDLE, OWN=IF, SCNT=0, rdata registers=0, all gnt/rvalid/err/m_en/m_we/busy=0, m_addr/m_wdata/m_wmask=0.
REQ-024 rst mid-access (ACC or RESP) SHALL abort: no rvalid pulse for aborted access; any m_en already issued is not retracted.
REQ-025 rst SHALL dominate all requests in the same cycle; no gnt while rst=1.

Configuration
REQ-026 Macro MEM_ARB_STARVE_EN: defined -> REQ-022 active with SCNT logic; undefined -> strict data priority, no SCNT register, STARVE_LIM ignored.

Verification
REQ-027 Fetch if_addr=0x100, mem word 0x40=0x00000073 -> if_gnt at N, m_en/m_addr=0x100 at N+1, if_rvalid=1, if_rdata=0x00000073 at N+3.
REQ-028 Store d_addr=0x4000, wmask=1111, wdata=0x87654321 then load same addr -> d_rvalid ack, then d_rdata=0x87654321, d_err=0.
REQ-029 Load d_addr=0x4002, wmask=1111 -> no m_en, d_rvalid=1, d_err=1; d_rdata unchanged.
REQ-030 if_req and d_req held high 20 cycles, STARVE_LIM=4, macro defined -> grant order D,D,D,D,IF repeating; macro undefined -> only D grants.
REQ-031 rst=1 in ACC cycle of a load -> next cycle IDLE, busy=0, no d_rvalid; all outputs zero.
